// File: rtl/simt_mask_if.sv
// Control-op / mask-stack bundle for the SIMT divergence controller.
// master: decoder plus mask stack (they drive op_* and stk_tos/stk_all_false).
// slave:  the divergence controller itself.
interface simt_mask_if #(
   parameter int N_CORES     = 4,
   parameter int STACK_DEPTH = 3,
   parameter int PC_W        = 8
);
   // decoder handshake
   logic                   op_valid;
   logic                   op_ready;
   logic [1:0]             op_code;
   logic [N_CORES-1:0]     pred;
   logic [PC_W-1:0]        op_target;

   // mask stack commands and status
   logic                   stk_push;
   logic                   stk_pop;
   logic                   stk_comp;
   logic [N_CORES-1:0]     stk_din;
   logic [N_CORES-1:0]     stk_tos;
   logic                   stk_all_false;

   // fetch redirect and retirement
   logic                   redirect_valid;
   logic [PC_W-1:0]        redirect_pc;
   logic                   done;
   logic                   err;
   logic [STACK_DEPTH-1:0] depth;

   modport master (
      output op_valid, op_code, pred, op_target, stk_tos, stk_all_false,
      input  op_ready, stk_push, stk_pop, stk_comp, stk_din,
             redirect_valid, redirect_pc, done, err, depth
   );

   modport slave (
      input  op_valid, op_code, pred, op_target, stk_tos, stk_all_false,
      output op_ready, stk_push, stk_pop, stk_comp, stk_din,
             redirect_valid, redirect_pc, done, err, depth
   );
endinterface

// File: rtl/simt_mask_ctrl.sv
// SIMT divergence controller: turns IF/ELSE/ENDIF ops into push/pop sequences
// on the per-warp predicate mask stack and requests a fetch redirect whenever
// the newly active mask is empty. All outputs toward the stack and fetch are
// registered; one op is in flight at a time.
module simt_mask_ctrl #(
   parameter int N_CORES     = 4,
   parameter int STACK_DEPTH = 3,
   parameter int PC_W        = 8
) (
   input  logic      clk,
   input  logic      reset,
   simt_mask_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      SETTLE,
      ELSE_PUSH,
      FINISH
   } state_t;

   typedef enum logic [1:0] {
      OP_ILL   = 2'b00,
      OP_IF    = 2'b01,
      OP_ELSE  = 2'b10,
      OP_ENDIF = 2'b11
   } op_t;

   localparam logic [STACK_DEPTH-1:0] MAX_DEPTH = '1;
   localparam logic [STACK_DEPTH-1:0] ONE       = STACK_DEPTH'(1);

   // sequencing context
   state_t             state,         state_n;
   op_t                op_q,          op_n;
   logic [N_CORES-1:0] cur_q,         cur_n;
   logic [PC_W-1:0]    target_q,      target_n;
   logic               else_pushed_q, else_pushed_n;

   // registered outputs
   logic                   push_q,  push_n;
   logic                   pop_q,   pop_n;
   logic [N_CORES-1:0]     din_q,   din_n;
   logic                   redir_q, redir_n;
   logic [PC_W-1:0]        rpc_q,   rpc_n;
   logic                   done_q,  done_n;
   logic                   err_q,   err_n;
   logic [STACK_DEPTH-1:0] depth_q, depth_n;

   logic accept;
   op_t  op_in;

   assign accept = bus.op_valid && (state == IDLE);
   assign op_in  = op_t'(bus.op_code);

   // Next-state and next-output decode for the whole op sequence.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_n       = state;
      op_n          = op_q;
      cur_n         = cur_q;
      target_n      = target_q;
      else_pushed_n = else_pushed_q;
      push_n        = 1'b0;
      pop_n         = 1'b0;
      din_n         = din_q;
      redir_n       = 1'b0;
      rpc_n         = rpc_q;
      done_n        = 1'b0;
      err_n         = 1'b0;
      depth_n       = depth_q;

      unique case (state)
         IDLE: begin
            if (accept) begin
               op_n          = op_in;
               cur_n         = bus.stk_tos;
               target_n      = bus.op_target;
               else_pushed_n = 1'b0;
               state_n       = CMD;
               unique case (op_in)
                  OP_IF: begin
                     if (depth_q == MAX_DEPTH) begin
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                        state_n = FINISH;
                     end else begin
                        push_n  = 1'b1;
                        din_n   = bus.stk_tos & bus.pred;
                        depth_n = depth_q + ONE;
                     end
                  end
                  OP_ELSE: begin
                     // Pop now, push the complemented-within-parent mask later.
                     if (depth_q == '0) begin
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                        state_n = FINISH;
                     end else begin
                        pop_n = 1'b1;
                     end
                  end
                  OP_ENDIF: begin
                     if (depth_q == '0) begin
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                        state_n = FINISH;
                     end else begin
                        pop_n   = 1'b1;
                        depth_n = depth_q - ONE;
                     end
                  end
                  default: begin
                     done_n  = 1'b1;
                     err_n   = 1'b1;
                     state_n = FINISH;
                  end
               endcase
            end
         end

         CMD: begin
            // The command is on the stack inputs this cycle; an ELSE whose
            // pop just went out still owes its push.
            if ((op_q == OP_ELSE) && !else_pushed_q) state_n = ELSE_PUSH;
            else                                       state_n = SETTLE;
         end

         ELSE_PUSH: begin
            // TOS is the parent mask now: enable only parent lanes that were
            // not taken by the IF side. An in-place complement would wrongly
            // wake lanes the parent had disabled.
            push_n        = 1'b1;
            din_n         = bus.stk_tos & ~cur_q;
            else_pushed_n = 1'b1;
            state_n       = CMD;
         end

         SETTLE: begin
            done_n  = 1'b1;
            state_n = FINISH;
            if ((op_q != OP_ENDIF) && bus.stk_all_false) begin
               redir_n = 1'b1;
               rpc_n   = target_q;
            end
         end

         FINISH: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and latched op context.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         op_q          <= OP_ILL;
         cur_q         <= '0;
         target_q      <= '0;
         else_pushed_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values and
         // the result does not depend on block evaluation order.
         state         <= state_n;
         op_q          <= op_n;
         cur_q         <= cur_n;
         target_q      <= target_n;
         else_pushed_q <= else_pushed_n;
      end
   end

   // Registered stack commands, redirect and retirement pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         push_q  <= 1'b0;
         pop_q   <= 1'b0;
         din_q   <= '0;
         redir_q <= 1'b0;
         rpc_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         depth_q <= '0;
      end else begin
         push_q  <= push_n;
         pop_q   <= pop_n;
         din_q   <= din_n;
         redir_q <= redir_n;
         rpc_q   <= rpc_n;
         done_q  <= done_n;
         err_q   <= err_n;
         depth_q <= depth_n;
      end
   end

   assign bus.op_ready       = (state == IDLE);
   assign bus.stk_push       = push_q;
   assign bus.stk_pop        = pop_q;
   assign bus.stk_comp       = 1'b0;
   assign bus.stk_din        = din_q;
   assign bus.redirect_valid = redir_q;
   assign bus.redirect_pc    = rpc_q;
   assign bus.done           = done_q;
   assign bus.err            = err_q;
   assign bus.depth          = depth_q;

endmodule
